// File: rtl/bemf_sample_seq.sv
// Back-EMF sample sequencer: sweeps enabled motors, takes high/low ADC samples per motor,
// issues them to the bemf update pipeline and stores the integrated result per motor.
module bemf_sample_seq #(
    parameter logic [7:0] ADC_TIMEOUT = 8'd255,
    parameter logic [3:0] CH_BASE     = 4'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_tick,
    input  logic [3:0]  mot_en,
    input  logic [3:0]  bemf_clear,
    output logic        adc_req,
    output logic [3:0]  adc_chan,
    input  logic        adc_ack,
    input  logic [9:0]  adc_data,
    output logic [9:0]  upd_adc_h,
    output logic [9:0]  upd_adc_l,
    output logic [1:0]  upd_mot_sel,
    output logic        upd_in_valid,
    output logic [21:0] upd_bemf_in,
    input  logic        upd_out_valid,
    input  logic [1:0]  upd_mot_sel_out,
    input  logic [21:0] upd_bemf_out,
    output logic [21:0] bemf0,
    output logic [21:0] bemf1,
    output logic [21:0] bemf2,
    output logic [21:0] bemf3,
    output logic        busy,
    output logic        overrun,
    output logic        adc_timeout_err
);

    typedef enum logic [2:0] {
        StIdle, StReqH, StWaitH, StReqL, StWaitL, StIssue, StWaitRes, StNext
    } state_e;

    state_e      state_q;
    logic [3:0]  mask_q;
    logic [1:0]  cur_q;
    logic [7:0]  tmo_q;
    logic [9:0]  samp_h_q;
    logic        pending_q;
    logic [3:0]  clr_fl_q;
    logic [21:0] acc_q [4];

    logic [1:0]  first_mot;
    logic [1:0]  next_mot;
    logic        next_found;
    logic [3:0]  ch_h;
    logic        wb_hit;

    // Descending scan so the lowest qualifying motor wins.
    always_comb begin
        first_mot  = '0;
        next_mot   = '0;
        next_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mot_en[i]) first_mot = 2'(i);
            if (mask_q[i] && (i > int'(cur_q))) begin
                next_found = 1'b1;
                next_mot   = 2'(i);
            end
        end
    end

    assign ch_h   = CH_BASE + {1'b0, cur_q, 1'b0};
    assign wb_hit = upd_out_valid && (upd_mot_sel_out == cur_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            mask_q          <= '0;
            cur_q           <= '0;
            tmo_q           <= '0;
            samp_h_q        <= '0;
            pending_q       <= 1'b0;
            clr_fl_q        <= '0;
            adc_req         <= 1'b0;
            adc_chan        <= '0;
            upd_adc_h       <= '0;
            upd_adc_l       <= '0;
            upd_mot_sel     <= '0;
            upd_in_valid    <= 1'b0;
            upd_bemf_in     <= '0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
            adc_timeout_err <= 1'b0;
            for (int m = 0; m < 4; m++) acc_q[m] <= '0;
        end else begin
            upd_in_valid <= 1'b0;
            if (sample_tick && (state_q != StIdle)) begin
                overrun   <= 1'b1;
                pending_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (sample_tick || pending_q) begin
                        pending_q <= 1'b0;
                        if (mot_en != 4'd0) begin
                            mask_q  <= mot_en;
                            cur_q   <= first_mot;
                            busy    <= 1'b1;
                            state_q <= StReqH;
                        end
                    end
                end
                StReqH: begin
                    adc_req  <= 1'b1;
                    adc_chan <= ch_h;
                    tmo_q    <= '0;
                    state_q  <= StWaitH;
                end
                StWaitH: begin
                    if (adc_ack) begin
                        samp_h_q <= adc_data;
                        adc_req  <= 1'b0;
                        state_q  <= StReqL;
                    end else if (tmo_q + 8'd1 == ADC_TIMEOUT) begin
                        adc_req         <= 1'b0;
                        adc_timeout_err <= 1'b1;
                        state_q         <= StNext;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                StReqL: begin
                    adc_req  <= 1'b1;
                    adc_chan <= ch_h + 4'd1;
                    tmo_q    <= '0;
                    state_q  <= StWaitL;
                end
                StWaitL: begin
                    if (adc_ack) begin
                        adc_req         <= 1'b0;
                        upd_in_valid    <= 1'b1;
                        upd_adc_h       <= samp_h_q;
                        upd_adc_l       <= adc_data;
                        upd_mot_sel     <= cur_q;
                        upd_bemf_in     <= acc_q[cur_q];
                        clr_fl_q[cur_q] <= 1'b0;
                        state_q         <= StIssue;
                    end else if (tmo_q + 8'd1 == ADC_TIMEOUT) begin
                        adc_req         <= 1'b0;
                        adc_timeout_err <= 1'b1;
                        state_q         <= StNext;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                StIssue: begin
                    state_q <= StWaitRes;
                end
                StWaitRes: begin
                    if (wb_hit) begin
                        if (!clr_fl_q[cur_q]) acc_q[cur_q] <= upd_bemf_out;
                        state_q <= StNext;
                    end
                end
                StNext: begin
                    if (next_found) begin
                        cur_q   <= next_mot;
                        state_q <= StReqH;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
            endcase
            // Placed last so a clear overrides a same-cycle writeback and marks the sample stale.
            for (int m = 0; m < 4; m++) begin
                if (bemf_clear[m]) begin
                    acc_q[m]    <= '0;
                    clr_fl_q[m] <= 1'b1;
                end
            end
        end
    end

    assign bemf0 = acc_q[0];
    assign bemf1 = acc_q[1];
    assign bemf2 = acc_q[2];
    assign bemf3 = acc_q[3];

endmodule
